// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memcontrol bus responder.
// Holds the responder FSM encoding, the latched operation type and the word size.
// Imported by mem_bus_responder and mem_bus_sram.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } resp_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mem_bus_sram.sv
// Single-port DEPTH x 32 synchronous array with per-byte write enables.
// Latency: write lands at the clock edge; read data is registered, valid the cycle after re.
// Backpressure: none; the caller sequences accesses.
// Ports: clk; we/be/wdata write controls; re read strobe; addr shared word index; rdata registered output.
module mem_bus_sram
    import mem_bus_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_BYTES-1:0]    be,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Array contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Bus-side responder serving memcontrol reads/writes from an on-chip word memory.
// Latency: request sampled at edge T0, rvalid/wack pulse in the cycle after edge T0+LATENCY.
// Backpressure: bus_full high from after T0 through the response cycle; requests ignored meanwhile.
// Ports: clk/rst; addr_in/wdata_in/byte_en/read_req/write_req from memcontrol;
//        rdata_out/rvalid/wack/err response, bus_full busy indication.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [3:0]  byte_en,
    input  logic        read_req,
    input  logic        write_req,
    output logic [31:0] rdata_out,
    output logic        rvalid,
    output logic        wack,
    output logic        bus_full,
    output logic        err
);

    localparam int         AW         = $clog2(DEPTH);
    localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

    resp_state_t   state_q,      state_d;
    logic [3:0]    count_q,      count_d;
    logic [AW-1:0] idx_q,        idx_d;
    logic [31:0]   wdata_q,      wdata_d;
    logic [3:0]    be_q,         be_d;
    op_t           op_q,         op_d;
    logic          addr_err_q,   addr_err_d;
    logic [31:0]   rdata_hold_q, rdata_hold_d;

    logic        commit;
    logic        sram_we;
    logic        sram_re;
    logic [31:0] sram_rdata;
    logic        resp_read;
    logic [31:0] rdata_mux;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            op_q         <= OP_READ;
            addr_err_q   <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            op_q         <= op_d;
            addr_err_q   <= addr_err_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        op_d       = op_q;
        addr_err_d = addr_err_q;

        case (state_q)
            IDLE: begin
                if (read_req || write_req) begin
                    // Read wins when both are raised, matching memcontrol's own priority.
                    op_d    = read_req ? OP_READ : OP_WRITE;
                    idx_d   = addr_in[AW+1:2];
                    wdata_d = wdata_in;
                    be_d    = byte_en;
                    // DEPTH is a power of two, so out of range means any bit above the index is set.
                    addr_err_d = (addr_in[1:0] != 2'b00) || (addr_in[31:AW+2] != '0);
                    count_d    = COUNT_INIT;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (count_q == 4'd0) begin
                    state_d = RESPOND;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The access happens on the edge that leaves BUSY; a reset before that edge drops it.
    assign commit  = (state_q == BUSY) && (count_q == 4'd0);
    assign sram_we = commit && (op_q == OP_WRITE) && !addr_err_q;
    assign sram_re = commit && (op_q == OP_READ) && !addr_err_q;

    mem_bus_sram #(
        .DEPTH (DEPTH)
    ) u_sram (
        .clk   (clk),
        .we    (sram_we),
        .re    (sram_re),
        .addr  (idx_q),
        .be    (be_q),
        .wdata (wdata_q),
        .rdata (sram_rdata)
    );

    // The array's registered output is shown only during a read response; otherwise
    // the last response is replayed from rdata_hold_q so writes never disturb rdata_out.
    assign resp_read    = (state_q == RESPOND) && (op_q == OP_READ);
    assign rdata_mux    = resp_read ? (addr_err_q ? 32'd0 : sram_rdata) : rdata_hold_q;
    assign rdata_hold_d = rdata_mux;

    assign rdata_out = rdata_mux;
    assign rvalid    = resp_read;
    assign wack      = (state_q == RESPOND) && (op_q == OP_WRITE);
    assign err       = (state_q == RESPOND) && addr_err_q;
    assign bus_full  = (state_q != IDLE);

endmodule
